consul_print_arbiter: RTL and testbench

- Shares the single Consul 260 print channel (8-bit valid/ready byte stream into the teletype driver) between NUM_REQ requesters, e.g. CPU I/O port, monitor/debugger, boot banner.
- Grants are line-atomic: an owner keeps the channel until it sends CR/LF, hits MAX_LINE bytes, or goes idle for IDLE_TIMEOUT cycles. Lines from different sources never interleave.
- Routes keyboard bytes from the driver to the requester that holds focus.

---
 rtl/consul_print_arbiter.sv | 166 ++++++++++++++++
 tb/tb_consul_print_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/consul_print_arbiter.sv
// Consul 260 print-channel arbiter: line-atomic sharing of one teletype byte stream,
// plus keyboard routing to the focus owner. Define CONSUL_ARB_PRIO_EN for fixed priority on requester 0.
module consul_print_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int MAX_LINE     = 80,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_vld_i,
  output logic [NUM_REQ-1:0]     req_rdy_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [7:0]             prn_data_o,
  output logic                   prn_vld_o,
  input  logic                   prn_rdy_i,
  input  logic [7:0]             kb_data_i,
  input  logic                   kb_vld_i,
  output logic [7:0]             kb_data_o,
  output logic [NUM_REQ-1:0]     kb_vld_o,
  output logic                   busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(MAX_LINE + 1);
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW:0]   NUM_REQ_W = (IW + 1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(MAX_LINE);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB = 2'd0, OWN = 2'd1, XFER = 2'd2} state_t;

  state_t              state_reg;
  logic [NUM_REQ-1:0]  grant_reg;
  logic [IW-1:0]       focus_reg;
  logic [IW-1:0]       rr_ptr_reg;
  logic [LW-1:0]       line_cnt_reg;
  logic [TW-1:0]       idle_cnt_reg;
  logic [7:0]          prn_data_reg;
  logic                prn_vld_reg;
  logic [7:0]          kb_data_reg;
  logic [NUM_REQ-1:0]  kb_vld_reg;

  logic [7:0]          req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]  cand;
  logic [IW:0]         rr_sum;
  logic [IW-1:0]       rr_idx;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  focus_onehot;
  logic [IW-1:0]       rr_next;
  logic                line_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data_i[8*gi +: 8];
    end
  endgenerate

  // First requesting index at or after rr_ptr, wrapping; requester 0 may jump the queue.
  always_comb begin
    cand       = req_vld_i;
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_idx     = '0;
`ifdef CONSUL_ARB_PRIO_EN
    if (req_vld_i[0]) begin
      pick_found = 1'b1;
    end
    cand[0] = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr_reg} + (IW + 1)'(k);
      if (rr_sum >= NUM_REQ_W) begin
        rr_sum = rr_sum - NUM_REQ_W;
      end
      rr_idx = rr_sum[IW-1:0];
      if (!pick_found && cand[rr_idx]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign focus_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << focus_reg;
  assign rr_next      = (focus_reg == LAST_IDX) ? '0 : focus_reg + IW'(1);
  assign line_end     = (prn_data_reg == 8'h0A) || (prn_data_reg == 8'h0D) ||
                        (line_cnt_reg == LINE_LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= ARB;
      grant_reg    <= '0;
      focus_reg    <= '0;
      rr_ptr_reg   <= '0;
      line_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      prn_data_reg <= '0;
      prn_vld_reg  <= 1'b0;
      kb_data_reg  <= '0;
      kb_vld_reg   <= '0;
    end else begin
      // Keyboard routing uses the focus held before this edge.
      kb_vld_reg <= kb_vld_i ? focus_onehot : '0;
      if (kb_vld_i) begin
        kb_data_reg <= kb_data_i;
      end

      case (state_reg)
        ARB: begin
          if (pick_found) begin
            grant_reg    <= pick_onehot;
            focus_reg    <= pick_idx;
            line_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            state_reg    <= OWN;
          end
        end
        OWN: begin
          if (req_vld_i[focus_reg]) begin
            prn_data_reg <= req_bytes[focus_reg];
            prn_vld_reg  <= 1'b1;
            line_cnt_reg <= line_cnt_reg + LW'(1);
            idle_cnt_reg <= '0;
            state_reg    <= XFER;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            grant_reg  <= '0;
            rr_ptr_reg <= rr_next;
            state_reg  <= ARB;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + TW'(1);
          end
        end
        XFER: begin
          if (prn_rdy_i) begin
            prn_vld_reg <= 1'b0;
            if (line_end) begin
              grant_reg  <= '0;
              rr_ptr_reg <= rr_next;
              state_reg  <= ARB;
            end else begin
              state_reg <= OWN;
            end
          end
        end
        default: begin
          state_reg <= ARB;
        end
      endcase
    end
  end

  assign req_rdy_o  = (state_reg == OWN) ? (req_vld_i & grant_reg) : '0;
  assign grant_o    = grant_reg;
  assign prn_data_o = prn_data_reg;
  assign prn_vld_o  = prn_vld_reg;
  assign kb_data_o  = kb_data_reg;
  assign kb_vld_o   = kb_vld_reg;
  assign busy_o     = (state_reg != ARB);

endmodule

// File: tb/tb_consul_print_arbiter.sv
// Directed bench for consul_print_arbiter: per-requester byte queues feed the DUT,
// accepted printer bytes are logged with their owner, and each step checks by immediate assertion.
module tb_consul_print_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [23:0] req_data = '0;
  logic [2:0]  req_vld = '0;
  logic [2:0]  req_rdy;
  logic [2:0]  grant;
  logic [7:0]  prn_data;
  logic        prn_vld;
  logic        prn_rdy;
  logic [7:0]  kb_in_data;
  logic        kb_in_vld;
  logic [7:0]  kb_out_data;
  logic [2:0]  kb_out_vld;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] b;
    logic [2:0] g;
    int         ep;
  } ent_t;

  ent_t       prn_log [$];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [2:0] hs = '0;
  logic [2:0] grant_prev = '0;
  int         epoch = 0;

  consul_print_arbiter #(.NUM_REQ(3), .MAX_LINE(80), .IDLE_TIMEOUT(1000)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .req_data_i (req_data),
    .req_vld_i  (req_vld),
    .req_rdy_o  (req_rdy),
    .grant_o    (grant),
    .prn_data_o (prn_data),
    .prn_vld_o  (prn_vld),
    .prn_rdy_i  (prn_rdy),
    .kb_data_i  (kb_in_data),
    .kb_vld_i   (kb_in_vld),
    .kb_data_o  (kb_out_data),
    .kb_vld_o   (kb_out_vld),
    .busy_o     (busy)
  );

  always #5 Clk = ~Clk;

  // Requester models: present queue heads, pop after a handshake seen before the edge.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
      hs       = '0;
      req_vld  = '0;
      req_data = '0;
    end else begin
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      if (hs[2] && q2.size() > 0) void'(q2.pop_front());
      req_vld         = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
      req_data[7:0]   = (q0.size() > 0) ? q0[0] : 8'h00;
      req_data[15:8]  = (q1.size() > 0) ? q1[0] : 8'h00;
      req_data[23:16] = (q2.size() > 0) ? q2[0] : 8'h00;
      #1 hs = req_rdy;
    end
  end

  always @(posedge Clk) begin
    if (Rst_n) begin
      if (grant != 3'b000 && grant_prev == 3'b000) epoch++;
      grant_prev = grant;
      if (prn_vld && prn_rdy) begin
        prn_log.push_back('{prn_data, grant, epoch});
        $display("[TB] prn byte %02h from grant %b", prn_data, grant);
      end
    end else begin
      grant_prev = '0;
    end
  end

  task automatic tick();
    @(negedge Clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    case (i)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (prn_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, " bytes arrived"}, 32'(prn_log.size() >= n), 32'd1);
  endtask

  task automatic chk_log(input int idx, input logic [7:0] b, input logic [2:0] g);
    if (idx < prn_log.size()) begin
      chk($sformatf("log%0d byte", idx), 32'(prn_log[idx].b), 32'(b));
      chk($sformatf("log%0d owner", idx), 32'(prn_log[idx].g), 32'(g));
    end else begin
      chk($sformatf("log%0d present", idx), 32'(prn_log.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick();
    tick();
    prn_log.delete();
    Rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    Rst_n      = 1'b0;
    prn_rdy    = 1'b1;
    kb_in_vld  = 1'b0;
    kb_in_data = 8'h00;
    tick();
    tick();

    chk("reset grant", 32'(grant), 32'd0);
    chk("reset prn_vld", 32'(prn_vld), 32'd0);
    chk("reset prn_data", 32'(prn_data), 32'd0);
    chk("reset kb_vld", 32'(kb_out_vld), 32'd0);
    chk("reset kb_data", 32'(kb_out_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    Rst_n = 1'b1;
    tick();

    // Focus is 0 out of reset.
    kb_in_data = 8'h61;
    kb_in_vld  = 1'b1;
    tick();
    kb_in_vld = 1'b0;
    chk("kb focus0 vld", 32'(kb_out_vld), 32'b001);
    chk("kb focus0 data", 32'(kb_out_data), 32'h61);
    tick();
    chk("kb pulse ends", 32'(kb_out_vld), 32'b000);
    chk("kb data holds", 32'(kb_out_data), 32'h61);

    // Req1 prints "AB\r".
    push(1, 8'h41);
    push(1, 8'h42);
    push(1, 8'h0D);
    tick();
    chk("grant not yet", 32'(grant), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    tick();
    chk("grant req1", 32'(grant), 32'b010);
    chk("rdy req1", 32'(req_rdy), 32'b010);
    chk("busy owned", 32'(busy), 32'd1);
    wait_log(3, 50, "line AB");
    chk_log(0, 8'h41, 3'b010);
    chk_log(1, 8'h42, 3'b010);
    chk_log(2, 8'h0D, 3'b010);
    chk("released after CR", 32'(grant), 32'd0);
    chk("free busy", 32'(busy), 32'd0);
    chk("prn_vld after line", 32'(prn_vld), 32'd0);

    // Req0 and req2 contend from reset; lines stay whole.
    do_reset();
    push(0, 8'h58);
    push(0, 8'h0A);
    push(2, 8'h59);
    push(2, 8'h0A);
    wait_log(4, 60, "two lines");
    chk_log(0, 8'h58, 3'b001);
    chk_log(1, 8'h0A, 3'b001);
    chk_log(2, 8'h59, 3'b100);
    chk_log(3, 8'h0A, 3'b100);

    // Req0 streams 85 bytes without CR; req2 waits with "Z\r".
    do_reset();
    for (int k = 0; k < 85; k++) push(0, 8'(32 + k));
    push(2, 8'h5A);
    push(2, 8'h0D);
    wait_log(87, 1500, "long line");
    for (int k = 0; k < 80; k++) chk_log(k, 8'(32 + k), 3'b001);
`ifdef CONSUL_ARB_PRIO_EN
    for (int k = 80; k < 85; k++) chk_log(k, 8'(32 + k), 3'b001);
    chk_log(85, 8'h5A, 3'b100);
    chk_log(86, 8'h0D, 3'b100);
`else
    chk_log(80, 8'h5A, 3'b100);
    chk_log(81, 8'h0D, 3'b100);
    for (int k = 82; k < 87; k++) chk_log(k, 8'(32 + k - 2), 3'b001);
`endif
    if (prn_log.size() >= 87) begin
      chk("line split epoch", 32'(prn_log[80].ep - prn_log[79].ep), 32'd1);
      chk("first grant spans 80", 32'(prn_log[79].ep - prn_log[0].ep), 32'd0);
    end

    // Req1 sends one byte then stalls; req0 queues behind it.
    do_reset();
    push(1, 8'h41);
    cnt = 0;
    while (grant !== 3'b010 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("stall owner", 32'(grant), 32'b010);
    push(0, 8'h51);
    push(0, 8'h0D);
    wait_log(1, 10, "stall byte");
    cnt = 0;
    while (grant !== 3'b000 && cnt < 1100) begin
      tick();
      cnt++;
    end
    chk("idle release near 1000", 32'(cnt >= 995 && cnt <= 1005), 32'd1);
    wait_log(3, 20, "after idle");
    chk_log(0, 8'h41, 3'b010);
    chk_log(1, 8'h51, 3'b001);
    chk_log(2, 8'h0D, 3'b001);

    // Printer back-pressure, then reset in the middle of a transfer.
    do_reset();
    prn_rdy = 1'b0;
    push(1, 8'h4D);
    push(1, 8'h0D);
    push(2, 8'h4E);
    push(2, 8'h0D);
    cnt = 0;
    while (prn_vld !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("xfer started", 32'(prn_vld), 32'd1);
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("stall prn_vld", 32'(prn_vld), 32'd1);
      chk("stall prn_data", 32'(prn_data), 32'h4D);
      chk("stall req_rdy", 32'(req_rdy), 32'd0);
    end
    prn_rdy = 1'b1;
    tick();
    prn_rdy = 1'b0;
    chk("accepted once", 32'(prn_log.size()), 32'd1);
    chk("accepted byte", 32'(prn_log.size() > 0 ? prn_log[0].b : 8'h00), 32'h4D);
    chk("vld drops", 32'(prn_vld), 32'd0);
    tick();
    chk("second xfer vld", 32'(prn_vld), 32'd1);
    chk("second xfer data", 32'(prn_data), 32'h0D);
    Rst_n = 1'b0;
    #1;
    chk("async rst prn_vld", 32'(prn_vld), 32'd0);
    chk("async rst prn_data", 32'(prn_data), 32'd0);
    chk("async rst grant", 32'(grant), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst req_rdy", 32'(req_rdy), 32'd0);
    tick();
    tick();
    Rst_n   = 1'b1;
    prn_rdy = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("no replay log", 32'(prn_log.size()), 32'd1);
    chk("no replay vld", 32'(prn_vld), 32'd0);

    // Focus follows the last owner; a same-edge grant does not redirect the key.
    do_reset();
    push(2, 8'h4B);
    push(2, 8'h0D);
    wait_log(2, 20, "focus line");
    chk("focus line released", 32'(grant), 32'd0);
    kb_in_data = 8'h35;
    kb_in_vld  = 1'b1;
    tick();
    kb_in_vld = 1'b0;
    chk("kb focus2 vld", 32'(kb_out_vld), 32'b100);
    chk("kb focus2 data", 32'(kb_out_data), 32'h35);
    tick();
    chk("kb focus2 ends", 32'(kb_out_vld), 32'b000);
    chk("kb focus2 holds", 32'(kb_out_data), 32'h35);
    push(1, 8'h57);
    push(1, 8'h0D);
    tick();
    kb_in_data = 8'h77;
    kb_in_vld  = 1'b1;
    tick();
    kb_in_vld = 1'b0;
    chk("kb old focus", 32'(kb_out_vld), 32'b100);
    chk("kb same-edge grant", 32'(grant), 32'b010);
    wait_log(4, 20, "focus move");
    kb_in_data = 8'h42;
    kb_in_vld  = 1'b1;
    tick();
    kb_in_vld = 1'b0;
    chk("kb focus1 vld", 32'(kb_out_vld), 32'b010);
    chk("kb focus1 data", 32'(kb_out_data), 32'h42);

    // Req0 has two lines, req1 one line, all pending.
    do_reset();
    push(0, 8'h50);
    push(0, 8'h0D);
    push(0, 8'h50);
    push(0, 8'h0D);
    push(1, 8'h52);
    push(1, 8'h0D);
    wait_log(6, 60, "contend");
`ifdef CONSUL_ARB_PRIO_EN
    chk_log(0, 8'h50, 3'b001);
    chk_log(1, 8'h0D, 3'b001);
    chk_log(2, 8'h50, 3'b001);
    chk_log(3, 8'h0D, 3'b001);
    chk_log(4, 8'h52, 3'b010);
    chk_log(5, 8'h0D, 3'b010);
`else
    chk_log(0, 8'h50, 3'b001);
    chk_log(1, 8'h0D, 3'b001);
    chk_log(2, 8'h52, 3'b010);
    chk_log(3, 8'h0D, 3'b010);
    chk_log(4, 8'h50, 3'b001);
    chk_log(5, 8'h0D, 3'b001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
